gate_scan: RTL
==============

# gate_scan

Parametrised, clocked truth-table generator for N-input gate functions. On a start request it sweeps every minterm 0..2^N-1, evaluates the selected gate function and captures each result into a 2^N-bit table register. It then signals completion. The block sits in the gates exercise set as the sequential, multi-input successor of the 2-input fixed-function gate modules, and replaces hand-written stimulus sweeps.

## Interface
- N, default 2: number of gate inputs; legal range 2..4; table width T = 2^N.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  scan request; sampled only in IDLE.
- op  in  3  function select; latched on accepted start.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse after the last minterm is captured.
- m  out  N  minterm currently being evaluated; bit N-1 is input a (MSB).
- s  out  1  registered result of the most recently captured minterm.
- table  out  T  captured truth table; bit i = f(minterm i).
- ones  out  N+1  count of true minterms (see Configuration).

## Operation
- Let x = m. Functions by latched op:
  - 0 AND: &x
  - 1 OR: |x
  - 2 NAND: ~&x
  - 3 NOR: ~|x
  - 4 XOR: ^x
  - 5 XNOR: ~^x
  - 6 INHIBIT-A: ~x[N-1] & (&x[N-2:0])
  - 7 INHIBIT-REST: x[N-1] & ~|x[N-2:0]
- States:
  - IDLE: busy=0, done=0. start=1 → SCAN. On the same edge: op_r<=op, table<=0, m<=0, s<=0, ones<=0.
  - SCAN: each edge performs table[m]<=f(m), s<=f(m), ones<=ones+f(m).
    - If m==T-1 → DONE with m held.
    - Else m<=m+1.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE unconditionally. start in DONE is ignored.
- start while in SCAN or DONE is ignored. op changes after acceptance have no effect.
- table, s, ones, m hold their last values in IDLE until the next accepted start.
- m never wraps inside a scan. Arithmetic is unsigned. ones saturates by construction: max = T fits in N+1 bits.
- Reset is asynchronous, with immediate effect in any state, including mid-scan:
  - state=IDLE
  - busy=0, done=0, m=0, s=0, table=0, ones=0, op_r=0
  - A partially filled table is discarded.

## Timing
- Edge E0 samples start=1. Cycles E0+1 .. E0+T are SCAN (busy=1). Minterm i is captured at edge E0+1+i.
- done is high in the cycle after edge E0+T. Total start-to-done latency is T+1 cycles: 5 for N=2, 9 for N=3, 17 for N=4.
- Earliest next accepted start is the edge after done, i.e. back-to-back scans every T+2 cycles.
- All outputs are registered. No combinational path from start or op to any output.

## Configuration
- GATE_SCAN_COUNT_EN defined: ones accumulates the number of true minterms and is valid when done is high.
- Not defined: the ones counter logic is removed and ones is tied to 0. Other behaviour and timing are identical.

## Test plan
- N=2, reset, then start with op=3 (NOR):
  - busy for 4 cycles; m steps 0,1,2,3.
  - done pulses at cycle 5; table=4'b0001.
  - ones=1 (with GATE_SCAN_COUNT_EN), else 0.
- N=2, op=6 (INHIBIT-A) → table=4'b0010. Then op=0 (AND) → 4'b1000. Then op=1 (OR) → 4'b1110. The three scans run back-to-back at a 6-cycle spacing.
- N=3, op=4 (XOR) → table=8'b10010110, ones=4. op=5 (XNOR) → 8'b01101001.
- Start pulse during SCAN while op is changed to 2:
  - No restart; latched op kept.
  - done arrives exactly T+1 cycles after the original start.
- Assert reset at the second SCAN cycle:
  - busy, done, m, s, table, ones go to 0 immediately, without waiting for a clock edge.
  - A subsequent start produces a full, correct table.
- N=4, op=7 → table=16'h0100 (only minterm 8 true), done at cycle 17.

Source files
------------

// File: rtl/gate_scan.sv
// rtl/gate_scan.sv - clocked truth-table generator sweeping all minterms of an N-input gate
// Optional ones counter enabled by defining GATE_SCAN_COUNT_EN.
module gate_scan #(
  parameter int N = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  output logic                  busy,
  output logic                  done,
  output logic [N-1:0]          m,
  output logic                  s,
  output logic [(1<<N)-1:0]     truth_table,
  output logic [N:0]            ones
);

  localparam int T = 1 << N;
  localparam logic [N-1:0] LAST = N'(T - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] op_r;
  logic       f;

  // Gate evaluated on the registered minterm, so no input-to-output path exists.
  always_comb begin
    f = 1'b0;
    case (op_r)
      3'd0: f = &m;
      3'd1: f = |m;
      3'd2: f = ~&m;
      3'd3: f = ~|m;
      3'd4: f = ^m;
      3'd5: f = ~^m;
      3'd6: f = ~m[N-1] & (&m[N-2:0]);
      3'd7: f = m[N-1] & ~(|m[N-2:0]);
      default: f = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_r        <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      m           <= '0;
      s           <= 1'b0;
      truth_table <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state       <= SCAN;
            busy        <= 1'b1;
            op_r        <= op;
            m           <= '0;
            s           <= 1'b0;
            truth_table <= '0;
          end
        end
        SCAN: begin
          truth_table[m] <= f;
          s              <= f;
          if (m == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            m <= m + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GATE_SCAN_COUNT_EN
  // Cannot overflow: at most T true minterms, and T fits in N+1 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones <= '0;
    end else if (state == IDLE && start) begin
      ones <= '0;
    end else if (state == SCAN) begin
      ones <= ones + (N+1)'(f);
    end
  end
`else
  assign ones = '0;
`endif

endmodule
